// File: rtl/multicycle_sequencer.sv
// Phase sequencer for the multi-cycle femtoRV32 core: FETCH/DECODE/EXEC/MEM/WB stepping,
// phase write enables, shared memory port handshake, illegal-opcode/bus-timeout traps.
module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [4:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    // The wait counter never exceeds TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic              TMO_EN    = (TIMEOUT != 0);

    state_t             r_state;
    state_t             w_next;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_retired;
    logic               r_halted;
    logic               r_trap;
    logic [1:0]         r_cause;
    logic [1:0]         w_cause;
    logic               w_legal;
    logic               w_wait_last;

    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE: w_legal = 1'b1;
            default:                                      w_legal = 1'b0;
        endcase
    end

    // Ready in the final allowed wait cycle still completes the request.
    assign w_wait_last = TMO_EN && (r_wait == WAIT_LAST);

    always_comb begin
        w_next   = r_state;
        w_cause  = 2'b00;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        rf_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_wait_last) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b10;
                end
            end
            S_DECODE: begin
                if (opcode == OP_SYSTEM) begin
                    w_next = S_HALT;
                end else if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    w_next  = S_TRAP;
                    w_cause = 2'b01;
                end
            end
            S_EXEC: begin
                if (opcode == OP_LOAD || opcode == OP_STORE) w_next = S_MEM;
                else if (opcode == OP_BRANCH || opcode == OP_FENCE) pc_we = 1'b1;
                else w_next = S_WB;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) pc_we = 1'b1;
                    else w_next = S_WB;
                end else if (w_wait_last) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b10;
                end
            end
            S_WB: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
            end
            default: ;
        endcase
        // A PC update marks instruction retire.
        if (pc_we) w_next = run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_retired <= '0;
            r_halted  <= 1'b0;
            r_trap    <= 1'b0;
            r_cause   <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_next != r_state && (w_next == S_FETCH || w_next == S_MEM))
                r_wait <= '0;
            else if (mem_req && !mem_ready)
                r_wait <= r_wait + WAIT_W'(1);
            if (pc_we) r_retired <= r_retired + CNT_W'(1);
            if (w_next == S_HALT) r_halted <= 1'b1;
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    assign halted     = r_halted;
    assign trap       = r_trap;
    assign trap_cause = r_cause;
    assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle enable patterns, traps, halt,
// retire counting with wrap (CNT_W=4), async reset mid-request.
module tb_multicycle_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic [4:0]       opcode;
    logic             mem_ready;
    logic             mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we;
    logic             halted, trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;
    logic [5:0]       ctl;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_sequencer #(.TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .rf_we(rf_we), .halted(halted), .trap(trap),
        .trap_cause(trap_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we}
    assign ctl = {mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we};

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_FWAIT = 6'b100000;
    localparam logic [5:0] C_FRDY  = 6'b100100;
    localparam logic [5:0] C_LD    = 6'b101000;
    localparam logic [5:0] C_STW   = 6'b111000;
    localparam logic [5:0] C_STR   = 6'b111010;
    localparam logic [5:0] C_BR    = 6'b000010;
    localparam logic [5:0] C_WB    = 6'b000011;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; drives mem_ready, checks the current cycle, advances one clock.
    task automatic cyc(input string tag, input logic rdy, input logic [5:0] exp);
        mem_ready = rdy;
        #1;
        chk(tag, 32'(ctl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", 32'(ctl), 32'(C_NONE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic branch_instr(input logic [4:0] op);
        opcode = op;
        cyc("br_f", 1'b1, C_FRDY);
        cyc("br_d", 1'b1, C_NONE);
        cyc("br_e", 1'b1, C_BR);
    endtask

    initial begin
        rst_n     = 1'b1;
        run       = 1'b0;
        opcode    = 5'b00000;
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctl0", 32'(ctl), 32'(C_NONE));
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // R-type: FETCH, DECODE, EXEC, WB
        run = 1'b1;
        opcode = 5'b01100;
        cyc("r_idle", 1'b1, C_NONE);
        cyc("r_f", 1'b1, C_FRDY);
        cyc("r_d", 1'b1, C_NONE);
        cyc("r_e", 1'b1, C_NONE);
        cyc("r_wb", 1'b1, C_WB);
        chk("r_retired", 32'(retired), 32'd1);

        // Load with two MEM wait cycles
        opcode = 5'b00000;
        cyc("ld_f", 1'b1, C_FRDY);
        cyc("ld_d", 1'b1, C_NONE);
        cyc("ld_e", 1'b1, C_NONE);
        cyc("ld_m0", 1'b0, C_LD);
        cyc("ld_m1", 1'b0, C_LD);
        cyc("ld_m2", 1'b1, C_LD);
        cyc("ld_wb", 1'b1, C_WB);
        chk("ld_retired", 32'(retired), 32'd2);

        // Store with one MEM wait cycle
        opcode = 5'b01000;
        cyc("st_f", 1'b1, C_FRDY);
        cyc("st_d", 1'b1, C_NONE);
        cyc("st_e", 1'b1, C_NONE);
        cyc("st_m0", 1'b0, C_STW);
        cyc("st_m1", 1'b1, C_STR);
        chk("st_retired", 32'(retired), 32'd3);

        branch_instr(5'b11000);
        chk("br_retired", 32'(retired), 32'd4);

        // OP-IMM with three FETCH wait cycles
        opcode = 5'b00100;
        cyc("fw_f0", 1'b0, C_FWAIT);
        cyc("fw_f1", 1'b0, C_FWAIT);
        cyc("fw_f2", 1'b0, C_FWAIT);
        cyc("fw_f3", 1'b1, C_FRDY);
        cyc("fw_d", 1'b1, C_NONE);
        cyc("fw_e", 1'b1, C_NONE);
        cyc("fw_wb", 1'b1, C_WB);
        chk("fw_retired", 32'(retired), 32'd5);

        // JAL retiring with run=0 returns to IDLE and stays there
        opcode = 5'b11011;
        cyc("jal_f", 1'b1, C_FRDY);
        cyc("jal_d", 1'b1, C_NONE);
        cyc("jal_e", 1'b1, C_NONE);
        run = 1'b0;
        cyc("jal_wb", 1'b1, C_WB);
        cyc("idle_hold0", 1'b1, C_NONE);
        cyc("idle_hold1", 1'b1, C_NONE);
        chk("jal_retired", 32'(retired), 32'd6);
        run = 1'b1;
        cyc("idle_go", 1'b1, C_NONE);

        // Counter wrap at 16 with CNT_W=4
        for (int i = 0; i < 9; i++) branch_instr(5'b11000);
        chk("wrap_15", 32'(retired), 32'd15);
        branch_instr(5'b00011);
        chk("wrap_0", 32'(retired), 32'd0);

        // Ready in the 16th FETCH cycle wins over timeout
        do_reset();
        opcode = 5'b01101;
        cyc("tr_idle", 1'b1, C_NONE);
        for (int i = 0; i < 15; i++) cyc("tr_fw", 1'b0, C_FWAIT);
        cyc("tr_f16", 1'b1, C_FRDY);
        chk("tr_notrap", 32'(trap), 32'd0);
        cyc("tr_d", 1'b1, C_NONE);
        cyc("tr_e", 1'b1, C_NONE);
        cyc("tr_wb", 1'b1, C_WB);
        chk("tr_retired", 32'(retired), 32'd1);

        // Async reset during a pending MEM request
        opcode = 5'b00000;
        cyc("rm_f", 1'b1, C_FRDY);
        cyc("rm_d", 1'b1, C_NONE);
        cyc("rm_e", 1'b1, C_NONE);
        mem_ready = 1'b0;
        #1;
        chk("rm_mem", 32'(ctl), 32'(C_LD));
        rst_n = 1'b0;
        #1;
        chk("rm_drop", 32'(ctl), 32'(C_NONE));
        chk("rm_retired", 32'(retired), 32'd0);
        run = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rm_idle0", 1'b1, C_NONE);
        cyc("rm_idle1", 1'b1, C_NONE);
        run = 1'b1;

        // Illegal opcode trap
        opcode = 5'b11111;
        cyc("il_idle", 1'b1, C_NONE);
        cyc("il_f", 1'b1, C_FRDY);
        cyc("il_d", 1'b1, C_NONE);
        chk("il_trap", 32'(trap), 32'd1);
        chk("il_cause", 32'(trap_cause), 32'd1);
        chk("il_halted", 32'(halted), 32'd0);
        cyc("il_hold0", 1'b1, C_NONE);
        cyc("il_hold1", 1'b0, C_NONE);
        chk("il_trap_hold", 32'(trap), 32'd1);
        chk("il_retired", 32'(retired), 32'd0);

        // SYSTEM opcode halts
        do_reset();
        chk("ht_trap_clr", 32'(trap), 32'd0);
        opcode = 5'b11100;
        cyc("ht_idle", 1'b1, C_NONE);
        cyc("ht_f", 1'b1, C_FRDY);
        cyc("ht_d", 1'b1, C_NONE);
        chk("ht_halted", 32'(halted), 32'd1);
        chk("ht_trap", 32'(trap), 32'd0);
        chk("ht_cause", 32'(trap_cause), 32'd0);
        cyc("ht_hold", 1'b1, C_NONE);
        chk("ht_halted_hold", 32'(halted), 32'd1);

        // FETCH never answered: timeout trap after 16 request cycles
        do_reset();
        opcode = 5'b01100;
        cyc("to_idle", 1'b1, C_NONE);
        for (int i = 0; i < 15; i++) cyc("to_fw", 1'b0, C_FWAIT);
        chk("to_pre_trap", 32'(trap), 32'd0);
        cyc("to_f16", 1'b0, C_FWAIT);
        chk("to_trap", 32'(trap), 32'd1);
        chk("to_cause", 32'(trap_cause), 32'd2);
        cyc("to_hold0", 1'b0, C_NONE);
        cyc("to_hold1", 1'b1, C_NONE);
        chk("to_cause_hold", 32'(trap_cause), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
